alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 93 +++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with single-cycle ops and a WIDTH-cycle shift-add multiplier
module alu_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t           r_state, w_next;
  logic [SHW-1:0]   r_cnt, w_sh;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, r_out, w_res, w_acc_next;
  logic             r_ill, w_ill, w_accept, w_is_mul, w_last;
  assign w_sh       = B[SHW-1:0];
  assign in_ready   = (r_state == IDLE) || (r_state == DONE && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_is_mul   = ALU_control == 4'b1010;
  assign w_last     = &r_cnt;
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign out_valid  = r_state == DONE;
  assign out        = r_out;
  assign zero       = r_out == '0;
  assign illegal    = r_ill;
  // Opcode decode for the single-cycle operations; MUL is handled by the iterative path
  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (ALU_control)
      4'b0000: w_res = A & B;
      4'b0001: w_res = A | B;
      4'b0010: w_res = A + B;
      4'b0110: w_res = A - B;
      4'b0111: w_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      4'b0011: w_res = A ^ B;
      4'b0100: w_res = A << w_sh;
      4'b0101: w_res = A >> w_sh;
      4'b1000: w_res = $signed(A) >>> w_sh;
      4'b1001: w_res = {{(WIDTH-1){1'b0}}, A < B};
      4'b1010: w_res = '0;
      default: w_ill = 1'b1;
    endcase
  end
  // Next state: MUL runs until the last multiplier bit; otherwise accepts win, DONE holds until taken
  always_comb begin
    w_next = r_state == MUL ? (w_last ? DONE : MUL) :
             w_accept ? (w_is_mul ? MUL : DONE) :
             (r_state == DONE && !out_ready) ? DONE : IDLE;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Result and multiplier datapath; the final iteration writes straight into the result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out    <= '0;
      r_ill    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= A;
      r_mplier <= B;
      if (!w_is_mul) begin
        r_out <= w_res;
        r_ill <= w_ill;
      end
    end else if (r_state == MUL) begin
      r_cnt    <= r_cnt + 1'b1;
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_last) begin
        r_out <= w_acc_next;
        r_ill <= 1'b0;
      end
    end
  end
endmodule
